// File: rtl/base2log.sv
// base2log: integer log-magnitude compressor.
// Maps an unsigned magnitude to SCALE*floor(log2(x)) plus a small fractional
// correction taken from the FRAC_BITS bits below the leading one.
// The output is registered, so results appear one cycle after the input.
module base2log #(
  parameter int unsigned IN_WIDTH  = 32,
  parameter int unsigned OUT_WIDTH = 8,
  parameter int unsigned SCALE     = 6,
  parameter int unsigned FRAC_BITS = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_i,
  input  logic [IN_WIDTH-1:0]  number_i,
  output logic                 valid_o,
  output logic [OUT_WIDTH-1:0] log_o
);

  localparam int unsigned E_W     = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
  localparam int unsigned EXT_W   = IN_WIDTH + FRAC_BITS;
  localparam logic [31:0] OUT_MAX = 32'((64'd1 << OUT_WIDTH) - 64'd1);

  // Fractional correction floor-ish(SCALE*log2(1+m/8)), tabulated for
  // SCALE=6 and 3 mantissa bits. Every entry is below SCALE, which keeps the
  // overall mapping monotonic across octave boundaries.
  function automatic logic [2:0] frac_lut(input logic [FRAC_BITS-1:0] m);
    logic [2:0] f;
    case (m)
      3'd0:    f = 3'd0;
      3'd1:    f = 3'd1;
      3'd2:    f = 3'd1;
      3'd3:    f = 3'd2;
      3'd4:    f = 3'd3;
      3'd5:    f = 3'd4;
      3'd6:    f = 3'd5;
      default: f = 3'd5;
    endcase
    return f;
  endfunction

  // Clamp the wide sum into the output range; only reachable with
  // parameter sets whose maximum log exceeds OUT_WIDTH bits.
  function automatic logic [OUT_WIDTH-1:0] sat_out(input logic [31:0] v);
    if (v > OUT_MAX) return OUT_MAX[OUT_WIDTH-1:0];
    return v[OUT_WIDTH-1:0];
  endfunction

  logic [E_W-1:0]       msb_p0;
  logic [EXT_W-1:0]     ext_p0;
  logic [FRAC_BITS-1:0] mant_p0;
  logic [31:0]          sum_p0;
  logic [OUT_WIDTH-1:0] log_p0;

  logic                 vld_p1;
  logic [OUT_WIDTH-1:0] log_p1;

  // Zero-extending below the LSB makes the mantissa select uniform even when
  // the leading one sits in the bottom FRAC_BITS positions.
  assign ext_p0 = {number_i, {FRAC_BITS{1'b0}}};

  // Stage 0: leading-one detect, mantissa extraction, scale and add.
  // Zero input falls through with msb=0 and mantissa=0, giving log 0.
  always_comb begin
    msb_p0 = '0;
    for (int i = 0; i < int'(IN_WIDTH); i++) begin
      if (number_i[i]) msb_p0 = E_W'(i);
    end
    mant_p0 = ext_p0[msb_p0 +: FRAC_BITS];
    sum_p0  = SCALE * 32'(msb_p0) + 32'(frac_lut(mant_p0));
    log_p0  = sat_out(sum_p0);
  end

  // Stage 1: output register; data follows every cycle, valid qualifies it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      log_p1 <= '0;
    end else begin
      vld_p1 <= valid_i;
      log_p1 <= log_p0;
    end
  end

  assign valid_o = vld_p1;
  assign log_o   = log_p1;

endmodule

// File: tb/tb_base2log.sv
// Testbench for base2log: directed and randomized stimulus compared against a
// behavioural model built from floor(log2(x)) and the fractional table.
module tb_base2log;

  logic        clk;
  logic        rst;
  logic        valid_i;
  logic [31:0] number_i;
  logic        valid_o;
  logic [7:0]  log_o;

  int passed = 0;
  int total  = 0;

  int ftab [8] = '{0, 1, 1, 2, 3, 4, 5, 5};

  base2log dut (
    .clk      (clk),
    .rst      (rst),
    .valid_i  (valid_i),
    .number_i (number_i),
    .valid_o  (valid_o),
    .log_o    (log_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // floor(log2(x)) by repeated halving; 0 treated like 1
  function automatic int msb_of(input logic [31:0] x);
    logic [31:0] t;
    int e;
    t = x;
    e = 0;
    while (t > 32'd1) begin
      t = t >> 1;
      e++;
    end
    return e;
  endfunction

  function automatic int model_log(input logic [31:0] x);
    int e;
    int m;
    logic [63:0] w;
    e = msb_of(x);
    w = ({32'd0, x} << 3) >> e;
    m = int'(w & 64'd7);
    return 6 * e + ftab[m];
  endfunction

  // Present one input, clock it in, and leave time just after the edge.
  task automatic apply(input logic [31:0] x, input logic v);
    number_i = x;
    valid_i  = v;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst      = 1'b1;
    valid_i  = 1'b1;
    number_i = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (valid_o !== 1'b0) $display("FAIL reset_valid: got %0b expected 0", valid_o);
    else passed++;
    total++;
    if (log_o !== 8'd0) $display("FAIL reset_log: got %0d expected 0", log_o);
    else passed++;
    #2 rst = 1'b0;
  endtask

  task automatic test_powers;
    for (int i = 0; i < 32; i++) begin
      apply(32'd1 << i, 1'b1);
      total++;
      if (valid_o !== 1'b1 || log_o !== 8'(6 * i))
        $display("FAIL pow2_%0d: got v=%0b log=%0d expected v=1 log=%0d", i, valid_o, log_o, 6 * i);
      else passed++;
    end
  endtask

  task automatic test_zero_one;
    logic [31:0] vals [3];
    int          exps [3];
    vals = '{32'd0, 32'd1, 32'hFFFF_FFFF};
    exps = '{0, 0, 191};
    for (int i = 0; i < 3; i++) begin
      apply(vals[i], 1'b1);
      total++;
      if (log_o !== 8'(exps[i]))
        $display("FAIL edge_%0h: got %0d expected %0d", vals[i], log_o, exps[i]);
      else passed++;
    end
  endtask

  task automatic test_fraction;
    int exps [8];
    exps = '{18, 19, 19, 20, 21, 22, 23, 23};
    for (int i = 0; i < 8; i++) begin
      apply(32'(8 + i), 1'b1);
      total++;
      if (log_o !== 8'(exps[i]))
        $display("FAIL frac_%0d: got %0d expected %0d", 8 + i, log_o, exps[i]);
      else passed++;
    end
  endtask

  task automatic test_monotonic;
    logic [63:0] acc;
    logic [31:0] x;
    int          prev;
    int          d;
    acc  = 64'd1;
    prev = 0;
    while (acc <= 64'hFFFF_FFFF) begin
      x = acc[31:0];
      apply(x, 1'(($urandom & 1) | 0));
      total++;
      if (log_o !== 8'(model_log(x)))
        $display("FAIL mono_model x=%0h: got %0d expected %0d", x, log_o, model_log(x));
      else passed++;
      total++;
      if (int'(log_o) < prev)
        $display("FAIL mono_order x=%0h: got %0d expected >= %0d", x, log_o, prev);
      else passed++;
      d = int'(log_o) - 6 * msb_of(x);
      total++;
      if (d < 0 || d > 5)
        $display("FAIL mono_frac x=%0h: got residue %0d expected 0..5", x, d);
      else passed++;
      total++;
      if (valid_o !== valid_i)
        $display("FAIL mono_valid x=%0h: got %0b expected %0b", x, valid_o, valid_i);
      else passed++;
      prev = int'(log_o);
      acc  = acc + 64'd1 + 64'($urandom_range(0, 7)) + (acc >> $urandom_range(1, 4));
    end
  endtask

  task automatic test_async_reset;
    apply(32'hABCD_1234, 1'b1);
    total++;
    if (valid_o !== 1'b1 || log_o !== 8'(model_log(32'hABCD_1234)))
      $display("FAIL prereset: got v=%0b log=%0d expected v=1 log=%0d", valid_o, log_o, model_log(32'hABCD_1234));
    else passed++;
    #2 rst = 1'b1;
    #1;
    total++;
    if (valid_o !== 1'b0 || log_o !== 8'd0)
      $display("FAIL async_reset: got v=%0b log=%0d expected v=0 log=0", valid_o, log_o);
    else passed++;
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    apply(32'd100, 1'b0);
    total++;
    if (valid_o !== 1'b0)
      $display("FAIL post_reset_idle: got %0b expected 0", valid_o);
    else passed++;
    apply(32'd1000, 1'b1);
    total++;
    if (valid_o !== 1'b1 || log_o !== 8'(model_log(32'd1000)))
      $display("FAIL post_reset_pulse: got v=%0b log=%0d expected v=1 log=%0d", valid_o, log_o, model_log(32'd1000));
    else passed++;
    apply(32'd5, 1'b0);
    total++;
    if (valid_o !== 1'b0)
      $display("FAIL post_reset_drop: got %0b expected 0", valid_o);
    else passed++;
  endtask

  task automatic test_back_to_back;
    logic [31:0] x;
    for (int i = 0; i < 40; i++) begin
      x = $urandom >> $urandom_range(0, 31);
      apply(x, 1'b1);
      total++;
      if (valid_o !== 1'b1 || log_o !== 8'(model_log(x)))
        $display("FAIL b2b_%0d x=%0h: got v=%0b log=%0d expected v=1 log=%0d", i, x, valid_o, log_o, model_log(x));
      else passed++;
    end
    apply(32'd0, 1'b0);
    total++;
    if (valid_o !== 1'b0)
      $display("FAIL b2b_end: got %0b expected 0", valid_o);
    else passed++;
  endtask

  initial begin
    rst      = 1'b1;
    valid_i  = 1'b0;
    number_i = '0;
    test_reset;
    @(posedge clk);
    #1;
    test_powers;
    test_zero_one;
    test_fraction;
    test_monotonic;
    test_async_reset;
    test_back_to_back;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
